// File: rtl/wb_stage_mx_if.sv
// wb_stage_mx_if: MEM->WB handshake bundle.
//   mem_wb_valid : MEM holds a valid instruction (MEM -> WB)
//   mem_wb_bus   : packed instruction payload, 183+NUM_EXC bits (MEM -> WB)
//   wb_allowin   : WB accepts this cycle (WB -> MEM)
// Modports: master = MEM side, slave = WB side.
interface wb_stage_mx_if #(
    parameter int unsigned NUM_EXC = 4
);
    logic                     mem_wb_valid;
    logic [183+NUM_EXC-1:0]   mem_wb_bus;
    logic                     wb_allowin;

    modport master (output mem_wb_valid, output mem_wb_bus, input wb_allowin);
    modport slave  (input mem_wb_valid, input mem_wb_bus, output wb_allowin);
endinterface

// File: rtl/wb_stage_mx.sv
// wb_stage_mx: writeback stage of the 5-stage LoongArch32 pipeline.
// Retires one instruction per cycle, drives register-file write-back and the
// CSR port, resolves prioritised exception flags into ecode/esubcode and
// raises exception/ertn flushes. CSR accesses stall WB for CSR_LAT cycles.
//
// Optional feature macro: WB_PERF_CNT_EN (retire/exception performance counters).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   mwb (slave)         mem_wb_valid / mem_wb_bus in, wb_allowin out
//   wb_id_bus           {rf_we, rf_waddr[5], rf_wdata[32], csr_busy} to ID
//   csr_num/re/we/wvalue/wmask, csr_rvalue   CSR unit port
//   wb_ex, ertn_flush   commit pulses; wb_csr_pc, wb_ecode, wb_esubcode
//   debug_wb_*          trace port
//   perf_retire_cnt, perf_exc_cnt            performance counters
module wb_stage_mx #(
    parameter int unsigned               NUM_EXC     = 4,
    parameter logic [15*NUM_EXC-1:0]     ECODE_TABLE = {6'h0C, 9'h0, 6'h0B, 9'h0, 6'h0D, 9'h0, 6'h08, 9'h0},
    parameter int unsigned               CSR_LAT     = 0
) (
    input  logic          clk,
    input  logic          reset,
    wb_stage_mx_if.slave  mwb,
    output logic [38:0]   wb_id_bus,
    output logic [13:0]   csr_num,
    output logic          csr_re,
    input  logic [31:0]   csr_rvalue,
    output logic          csr_we,
    output logic [31:0]   csr_wvalue,
    output logic [31:0]   csr_wmask,
    output logic          wb_ex,
    output logic          ertn_flush,
    output logic [31:0]   wb_csr_pc,
    output logic [5:0]    wb_ecode,
    output logic [8:0]    wb_esubcode,
    output logic [31:0]   debug_wb_pc,
    output logic [3:0]    debug_wb_rf_we,
    output logic [4:0]    debug_wb_rf_wnum,
    output logic [31:0]   debug_wb_rf_wdata,
    output logic [63:0]   perf_retire_cnt,
    output logic [31:0]   perf_exc_cnt
);

    localparam logic [2:0] CSR_LAT_W = 3'(CSR_LAT);

    typedef struct packed {
        logic               gr_we;
        logic [31:0]        pc;
        logic [31:0]        inst;
        logic [31:0]        result;
        logic [4:0]         dest;
        logic               csr_we;
        logic               csr_re;
        logic [13:0]        csr_num;
        logic [31:0]        csr_wmask;
        logic [31:0]        csr_wvalue;
        logic               ertn;
        logic [NUM_EXC-1:0] exc_vec;
    } payload_t;

    payload_t    pl_in;
    payload_t    pl;
    logic        wb_valid;
    logic [2:0]  csr_cnt;

    logic        wb_ready_go;
    logic        wb_commit;
    logic        commit_flush;
    logic        exc_hit;
    logic        exc_found;
    logic [14:0] exc_entry;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        csr_acc;
    logic        unused_inst;

    assign pl_in       = mwb.mem_wb_bus;
    assign unused_inst = ^pl.inst;

    assign wb_ready_go    = ~wb_valid | (csr_cnt == 3'd0);
    assign mwb.wb_allowin = ~wb_valid | wb_ready_go;
    assign wb_commit      = wb_valid & wb_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            pl       <= '0;
            csr_cnt  <= '0;
        end else begin
            if (mwb.wb_allowin)
                wb_valid <= mwb.mem_wb_valid & ~commit_flush;
            // The counter is reloaded on every accept, even one dropped by a
            // flush; it is harmless then because wb_valid gates ready_go.
            if (mwb.mem_wb_valid & mwb.wb_allowin) begin
                pl      <= pl_in;
                csr_cnt <= (pl_in.csr_re | pl_in.csr_we) ? CSR_LAT_W : 3'd0;
            end else if (csr_cnt != 3'd0) begin
                csr_cnt <= csr_cnt - 3'd1;
            end
        end
    end

    // Lowest set index wins.
    always_comb begin
        exc_entry = '0;
        exc_found = 1'b0;
        for (int unsigned i = 0; i < NUM_EXC; i++) begin
            if (!exc_found && pl.exc_vec[i]) begin
                exc_entry = ECODE_TABLE[15*i +: 15];
                exc_found = 1'b1;
            end
        end
    end

    assign exc_hit      = |pl.exc_vec;
    assign wb_ex        = wb_commit & exc_hit;
    assign ertn_flush   = wb_commit & pl.ertn & ~exc_hit;
    assign commit_flush = wb_ex | ertn_flush;
    assign rf_we        = wb_commit & pl.gr_we & ~exc_hit;
    assign csr_we       = wb_commit & pl.csr_we & ~exc_hit;

    // Read enable stays up for the whole residency so csr_rvalue is stable
    // by the time the stall expires.
    assign csr_acc    = wb_valid & (pl.csr_re | pl.csr_we);
    assign csr_re     = csr_acc;
    assign csr_num    = pl.csr_num;
    assign csr_wvalue = pl.csr_wvalue;
    assign csr_wmask  = pl.csr_wmask;

    assign rf_wdata  = csr_re ? csr_rvalue : pl.result;
    assign wb_id_bus = {rf_we, pl.dest, rf_wdata, csr_acc};

    assign wb_csr_pc                 = pl.pc;
    assign {wb_ecode, wb_esubcode}   = exc_entry;

    assign debug_wb_pc       = pl.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = pl.dest;
    assign debug_wb_rf_wdata = rf_wdata;

`ifdef WB_PERF_CNT_EN
    logic [63:0] retire_q;
    logic [31:0] exc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_q <= '0;
            exc_q    <= '0;
        end else begin
            if (wb_commit)
                retire_q <= retire_q + 64'd1;
            if (wb_ex)
                exc_q <= exc_q + 32'd1;
        end
    end

    assign perf_retire_cnt = retire_q;
    assign perf_exc_cnt    = exc_q;
`else
    assign perf_retire_cnt = '0;
    assign perf_exc_cnt    = '0;
`endif

endmodule

// File: tb/tb_wb_stage_mx.sv
// Testbench for wb_stage_mx (CSR_LAT=2, NUM_EXC=4, default ecode table).
module tb_wb_stage_mx;

    localparam int unsigned LAT = 2;
`ifdef WB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic        gr_we;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        csr_we;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        ertn;
        logic [3:0]  exc_vec;
    } ins_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] csr_rvalue;
    logic [38:0] wb_id_bus;
    logic [13:0] csr_num;
    logic        csr_re, csr_we, wb_ex, ertn_flush;
    logic [31:0] csr_wvalue, csr_wmask, wb_csr_pc, debug_wb_pc, debug_wb_rf_wdata;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [63:0] perf_retire_cnt;
    logic [31:0] perf_exc_cnt;

    logic        o_rf_we, o_busy;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic [399:0] all_out;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    wb_stage_mx_if #(.NUM_EXC(4)) mwb ();

    wb_stage_mx #(.NUM_EXC(4), .CSR_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .mwb(mwb),
        .wb_id_bus(wb_id_bus), .csr_num(csr_num), .csr_re(csr_re),
        .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wvalue(csr_wvalue),
        .csr_wmask(csr_wmask), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
        .wb_csr_pc(wb_csr_pc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .perf_retire_cnt(perf_retire_cnt), .perf_exc_cnt(perf_exc_cnt)
    );

    assign o_rf_we = wb_id_bus[38];
    assign o_waddr = wb_id_bus[37:33];
    assign o_wdata = wb_id_bus[32:1];
    assign o_busy  = wb_id_bus[0];
    assign all_out = 400'({wb_id_bus, csr_num, csr_re, csr_we, csr_wvalue, csr_wmask,
                           wb_ex, ertn_flush, wb_csr_pc, wb_ecode, wb_esubcode,
                           debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum,
                           debug_wb_rf_wdata, perf_retire_cnt, perf_exc_cnt});

    // Architectural ecode/esubcode: ADEF > INE > SYS > BRK.
    function automatic logic [14:0] ref_ecode(input logic [3:0] v);
        if (v[0])      return {6'h08, 9'h0};
        else if (v[1]) return {6'h0D, 9'h0};
        else if (v[2]) return {6'h0B, 9'h0};
        else if (v[3]) return {6'h0C, 9'h0};
        else           return 15'h0;
    endfunction

    function automatic ins_t alu(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
        ins_t i;
        i = '0;
        i.gr_we  = 1'b1;
        i.pc     = pc;
        i.inst   = $urandom;
        i.dest   = d;
        i.result = r;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.gr_we      = ($urandom % 4) != 0;
        i.pc         = $urandom;
        i.inst       = $urandom;
        i.result     = $urandom;
        i.dest       = 5'($urandom);
        i.csr_we     = ($urandom % 5) == 0;
        i.csr_re     = ($urandom % 5) == 0;
        i.csr_num    = 14'($urandom);
        i.csr_wmask  = $urandom;
        i.csr_wvalue = $urandom;
        i.ertn       = ($urandom % 8) == 0;
        i.exc_vec    = (($urandom % 6) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        return i;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic present(input ins_t i, input logic v);
        mwb.mem_wb_valid = v;
        mwb.mem_wb_bus   = i;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        csr_rvalue = $urandom;
        present(rand_ins(), 1'b1);
        repeat (3) step();
        reset = 1'b0;
        mwb.mem_wb_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (all_out !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs_zero[%0d]: got %h required 0", k, all_out);
            end
            vectors++;
            if (mwb.wb_allowin !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_allowin[%0d]: got %b required 1", k, mwb.wb_allowin);
            end
            step();
        end
    endtask

    task automatic test_add_back_to_back();
        ins_t a;
        ins_t b[3];
        a = alu(32'h1C00_0000, 5'd5, 32'h1234);
        present(a, 1'b1);
        step();
        vectors++;
        if ({mwb.wb_allowin, o_rf_we, debug_wb_rf_we, debug_wb_rf_wnum, o_wdata, debug_wb_pc}
            !== {1'b1, 1'b1, 4'hF, 5'd5, 32'h1234, 32'h1C00_0000}) begin
            miscompares++;
            $display("FAIL add_commit: got we=%b wnum=%0d wdata=%h pc=%h required we=1 wnum=5 wdata=1234 pc=1c000000",
                     o_rf_we, debug_wb_rf_wnum, o_wdata, debug_wb_pc);
        end
        for (int k = 0; k < 3; k++) b[k] = alu(32'h1C00_0004 + 32'(4*k), 5'(10 + k), $urandom);
        for (int k = 0; k < 3; k++) begin
            present(b[k], 1'b1);
            step();
            vectors++;
            if ({mwb.wb_allowin, o_rf_we, o_waddr, o_wdata, debug_wb_pc}
                !== {1'b1, 1'b1, b[k].dest, b[k].result, b[k].pc}) begin
                miscompares++;
                $display("FAIL b2b_retire[%0d]: got we=%b waddr=%0d wdata=%h pc=%h required we=1 waddr=%0d wdata=%h pc=%h",
                         k, o_rf_we, o_waddr, o_wdata, debug_wb_pc, b[k].dest, b[k].result, b[k].pc);
            end
        end
        mwb.mem_wb_valid = 1'b0;
        step();
        vectors++;
        if (o_rf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got rf_we=%b required 0", o_rf_we);
        end
    endtask

    task automatic test_csr_stall();
        ins_t c;
        ins_t f;
        c = alu(32'h1C00_0100, 5'd7, 32'hDEAD_0000);
        c.csr_re  = 1'b1;
        c.csr_num = 14'h6;
        f = alu(32'h1C00_0104, 5'd9, 32'h5555);
        csr_rvalue = 32'hABCD;
        present(c, 1'b1);
        step();
        present(f, 1'b1);
        for (int s = 0; s < int'(LAT); s++) begin
            vectors++;
            if ({mwb.wb_allowin, o_busy, o_rf_we, csr_re, csr_num} !== {1'b0, 1'b1, 1'b0, 1'b1, 14'h6}) begin
                miscompares++;
                $display("FAIL csr_stall[%0d]: got allowin=%b busy=%b rf_we=%b csr_re=%b num=%h required 0 1 0 1 0006",
                         s, mwb.wb_allowin, o_busy, o_rf_we, csr_re, csr_num);
            end
            step();
        end
        vectors++;
        if ({mwb.wb_allowin, o_busy, o_rf_we, o_waddr, o_wdata} !== {1'b1, 1'b1, 1'b1, 5'd7, 32'hABCD}) begin
            miscompares++;
            $display("FAIL csr_commit: got allowin=%b busy=%b rf_we=%b waddr=%0d wdata=%h required 1 1 1 7 0000abcd",
                     mwb.wb_allowin, o_busy, o_rf_we, o_waddr, o_wdata);
        end
        step();
        mwb.mem_wb_valid = 1'b0;
        vectors++;
        if ({o_busy, o_rf_we, o_waddr, o_wdata} !== {1'b0, 1'b1, 5'd9, 32'h5555}) begin
            miscompares++;
            $display("FAIL csr_held_next: got busy=%b rf_we=%b waddr=%0d wdata=%h required 0 1 9 00005555",
                     o_busy, o_rf_we, o_waddr, o_wdata);
        end
        step();
        vectors++;
        if (o_rf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL csr_no_repeat: got rf_we=%b required 0", o_rf_we);
        end
    endtask

    task automatic test_exception();
        ins_t e;
        ins_t d;
        e = alu(32'h1C00_0200, 5'd4, $urandom);
        e.csr_we  = 1'b1;
        e.exc_vec = 4'b0110;
        d = alu(32'h1C00_0204, 5'd6, $urandom);
        d.csr_re = 1'b1;
        present(e, 1'b1);
        step();
        mwb.mem_wb_valid = 1'b0;
        for (int s = 0; s < int'(LAT); s++) begin
            vectors++;
            if ({wb_ex, csr_we, o_rf_we} !== 3'b000) begin
                miscompares++;
                $display("FAIL exc_stall[%0d]: got ex=%b csr_we=%b rf_we=%b required 000", s, wb_ex, csr_we, o_rf_we);
            end
            step();
        end
        present(d, 1'b1);
        vectors++;
        if ({wb_ex, ertn_flush, o_rf_we, csr_we, wb_ecode, wb_esubcode, wb_csr_pc}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 6'h0D, 9'h0, 32'h1C00_0200}) begin
            miscompares++;
            $display("FAIL exc_commit: got ex=%b ertn=%b rf_we=%b csr_we=%b ecode=%h esub=%h pc=%h required 1 0 0 0 0d 000 1c000200",
                     wb_ex, ertn_flush, o_rf_we, csr_we, wb_ecode, wb_esubcode, wb_csr_pc);
        end
        step();
        mwb.mem_wb_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            vectors++;
            if ({mwb.wb_allowin, o_busy, o_rf_we, wb_ex} !== 4'b1000) begin
                miscompares++;
                $display("FAIL exc_drop[%0d]: got allowin=%b busy=%b rf_we=%b ex=%b required 1000",
                         s, mwb.wb_allowin, o_busy, o_rf_we, wb_ex);
            end
            step();
        end
    endtask

    task automatic test_ertn();
        ins_t e1;
        ins_t e2;
        e1 = alu(32'h1C00_0300, 5'd0, 32'h0);
        e1.gr_we   = 1'b0;
        e1.ertn    = 1'b1;
        e1.exc_vec = 4'b0100;
        e2 = e1;
        e2.exc_vec = 4'b0000;
        present(e1, 1'b1);
        step();
        mwb.mem_wb_valid = 1'b0;
        vectors++;
        if ({wb_ex, ertn_flush, wb_ecode} !== {1'b1, 1'b0, 6'h0B}) begin
            miscompares++;
            $display("FAIL ertn_vs_exc: got ex=%b ertn=%b ecode=%h required 1 0 0b", wb_ex, ertn_flush, wb_ecode);
        end
        step();
        present(e2, 1'b1);
        step();
        mwb.mem_wb_valid = 1'b0;
        vectors++;
        if ({wb_ex, ertn_flush} !== 2'b01) begin
            miscompares++;
            $display("FAIL ertn_commit: got ex=%b ertn=%b required 01", wb_ex, ertn_flush);
        end
        step();
        vectors++;
        if (ertn_flush !== 1'b0) begin
            miscompares++;
            $display("FAIL ertn_one_cycle: got ertn=%b required 0", ertn_flush);
        end
    endtask

    task automatic test_reset_mid_stall();
        ins_t c;
        c = alu(32'h1C00_0400, 5'd8, $urandom);
        c.csr_re = 1'b1;
        present(c, 1'b1);
        step();
        mwb.mem_wb_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            vectors++;
            if ({mwb.wb_allowin, o_busy, o_rf_we, wb_ex} !== 4'b1000) begin
                miscompares++;
                $display("FAIL reset_mid_stall[%0d]: got allowin=%b busy=%b rf_we=%b ex=%b required 1000",
                         s, mwb.wb_allowin, o_busy, o_rf_we, wb_ex);
            end
            step();
        end
    endtask

    task automatic test_perf();
        ins_t p;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            p = alu($urandom, 5'($urandom), $urandom);
            if (k == 3 || k == 7) p.exc_vec = 4'($urandom_range(1, 15));
            present(p, 1'b1);
            step();
            mwb.mem_wb_valid = 1'b0;
            step();
        end
        vectors++;
        if ({perf_retire_cnt, perf_exc_cnt} !== {(PERF ? 64'd10 : 64'd0), (PERF ? 32'd2 : 32'd0)}) begin
            miscompares++;
            $display("FAIL perf_counts: got retire=%0d exc=%0d required retire=%0d exc=%0d",
                     perf_retire_cnt, perf_exc_cnt, PERF ? 10 : 0, PERF ? 2 : 0);
        end
    endtask

    // Timeline model: an accepted instruction commits at a known cycle
    // (next cycle, plus LAT for CSR access); WB only takes a new one when free.
    task automatic test_random();
        ins_t   cur;
        ins_t   nxt;
        bit     holding = 1'b0;
        int     commit_at = 0;
        longint n_ret = 0;
        int     n_exc = 0;
        bit     v, committing, stalled, exc, e_rf, e_ex, e_ertn, e_cwe, e_busy;
        cur = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int it = 0; it < 600; it++) begin
            csr_rvalue = $urandom;
            nxt = rand_ins();
            v = (it < 596) && (($urandom % 4) != 0);
            present(nxt, v);
            #1;
            committing = holding && (cyc == commit_at);
            stalled    = holding && (cyc < commit_at);
            exc        = cur.exc_vec != 4'h0;
            e_rf   = committing && cur.gr_we && !exc;
            e_ex   = committing && exc;
            e_ertn = committing && cur.ertn && !exc;
            e_cwe  = committing && cur.csr_we && !exc;
            e_busy = holding && (cur.csr_re || cur.csr_we);
            vectors++;
            if ({mwb.wb_allowin, o_rf_we, wb_ex, ertn_flush, csr_we, o_busy, csr_re}
                !== {!stalled, e_rf, e_ex, e_ertn, e_cwe, e_busy, e_busy}) begin
                miscompares++;
                $display("FAIL rand_ctrl[%0d]: got allow/rf/ex/ertn/cwe/busy/cre=%b required %b", it,
                         {mwb.wb_allowin, o_rf_we, wb_ex, ertn_flush, csr_we, o_busy, csr_re},
                         {!stalled, e_rf, e_ex, e_ertn, e_cwe, e_busy, e_busy});
            end
            if (e_rf) begin
                vectors++;
                if ({debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_pc}
                    !== {cur.dest, ((cur.csr_re || cur.csr_we) ? csr_rvalue : cur.result), cur.pc}) begin
                    miscompares++;
                    $display("FAIL rand_rf[%0d]: got wnum=%0d wdata=%h pc=%h required wnum=%0d wdata=%h pc=%h", it,
                             debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_pc, cur.dest,
                             ((cur.csr_re || cur.csr_we) ? csr_rvalue : cur.result), cur.pc);
                end
            end
            if (e_ex) begin
                vectors++;
                if ({wb_ecode, wb_esubcode, wb_csr_pc} !== {ref_ecode(cur.exc_vec), cur.pc}) begin
                    miscompares++;
                    $display("FAIL rand_exc[%0d]: got code=%h pc=%h required code=%h pc=%h", it,
                             {wb_ecode, wb_esubcode}, wb_csr_pc, ref_ecode(cur.exc_vec), cur.pc);
                end
            end
            if (e_cwe) begin
                vectors++;
                if ({csr_num, csr_wvalue, csr_wmask} !== {cur.csr_num, cur.csr_wvalue, cur.csr_wmask}) begin
                    miscompares++;
                    $display("FAIL rand_csrw[%0d]: got %h/%h/%h required %h/%h/%h", it,
                             csr_num, csr_wvalue, csr_wmask, cur.csr_num, cur.csr_wvalue, cur.csr_wmask);
                end
            end
            if (committing) begin
                n_ret++;
                if (exc) n_exc++;
            end
            if (!stalled) begin
                if (v && !(e_ex || e_ertn)) begin
                    holding   = 1'b1;
                    cur       = nxt;
                    commit_at = cyc + 1 + ((nxt.csr_re || nxt.csr_we) ? int'(LAT) : 0);
                end else begin
                    holding = 1'b0;
                end
            end
            step();
        end
        vectors++;
        if ({perf_retire_cnt, perf_exc_cnt} !== {(PERF ? 64'(n_ret) : 64'd0), (PERF ? 32'(n_exc) : 32'd0)}) begin
            miscompares++;
            $display("FAIL rand_perf: got retire=%0d exc=%0d required retire=%0d exc=%0d",
                     perf_retire_cnt, perf_exc_cnt, PERF ? n_ret : 0, PERF ? n_exc : 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        csr_rvalue = '0;
        mwb.mem_wb_valid = 1'b0;
        mwb.mem_wb_bus = '0;
        test_reset();
        test_add_back_to_back();
        test_csr_stall();
        test_exception();
        test_ertn();
        test_reset_mid_stall();
        test_perf();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_stage_mx.md
# wb_stage_mx

Parametrised writeback stage for the 5-stage LoongArch32 pipeline, between MEM and the register file/CSR unit.
- Retires one instruction per cycle; drives register-file write-back to ID and the CSR read/write port.
- Resolves up to NUM_EXC prioritised exception flags into ecode/esubcode and raises the exception/ertn flush.
- Stalls for a configurable number of cycles on CSR accesses.

## Interface
- NUM_EXC, 4: exception flags carried on the MEM→WB bus (1..16); index 0 = highest priority.
- ECODE_TABLE, {6'h0C,9'h0, 6'h0B,9'h0, 6'h0D,9'h0, 6'h08,9'h0}: packed {ecode,esubcode} table; entry i at [15*i+14:15*i]. Default: idx0 ADEF, idx1 INE, idx2 SYS, idx3 BRK.
- CSR_LAT, 0: extra WB cycles for an instruction with csr_re or csr_we (0..7).
- clk  in  1  clock; one clock.
- reset  in  1  synchronous, active-high reset.
- mem_wb_valid  in  1  MEM holds a valid instruction.
- mem_wb_bus  in  183+NUM_EXC  MSB→LSB: gr_we, pc[32], inst[32], result[32], dest[5], csr_we, csr_re, csr_num[14], csr_wmask[32], csr_wvalue[32], ertn, exc_vec[NUM_EXC].
- wb_allowin  out  1  WB accepts this cycle.
- wb_id_bus  out  39  {rf_we, rf_waddr[5], rf_wdata[32], csr_busy}.
- csr_num  out  14  CSR index.
- csr_re  out  1  CSR read enable.
- csr_rvalue  in  32  CSR read data, valid CSR_LAT cycles after entry.
- csr_we  out  1  CSR write strobe.
- csr_wvalue  out  32  CSR write data.
- csr_wmask  out  32  CSR write mask.
- wb_ex  out  1  exception commit pulse.
- ertn_flush  out  1  ertn commit pulse.
- wb_csr_pc  out  32  PC of the WB instruction.
- wb_ecode  out  6  exception code.
- wb_esubcode  out  9  exception subcode.
- debug_wb_pc  out  32  trace PC.
- debug_wb_rf_we  out  4  trace write enable.
- debug_wb_rf_wnum  out  5  trace write register.
- debug_wb_rf_wdata  out  32  trace write data.
- perf_retire_cnt  out  64  retired-instruction count.
- perf_exc_cnt  out  32  exception count.

## Operation
- State: wb_valid, payload register (BUS_W bits), 3-bit csr_cnt. Reset clears all three; every output then reads 0.
- wb_ready_go = ~wb_valid | (csr_cnt == 0).
- wb_allowin = ~wb_valid | wb_ready_go.
- On wb_allowin: wb_valid <= mem_wb_valid & ~commit_flush, where commit_flush = wb_ex | ertn_flush. An instruction arriving in a flush cycle is dropped.
- Payload loads only on mem_wb_valid & wb_allowin.
- On load, csr_cnt <= (csr_re|csr_we) ? CSR_LAT : 0; it decrements while nonzero.
- exc_hit = |exc_vec. Priority encoder picks the lowest set index; wb_ecode/wb_esubcode come from that entry, 0 if none.
- wb_ex = wb_valid & exc_hit & wb_ready_go.
- ertn_flush = wb_valid & ertn & ~exc_hit & wb_ready_go. An exception beats ertn.
- rf_we = wb_valid & gr_we & ~exc_hit & wb_ready_go.
- csr_we = wb_valid & csr_we_f & ~exc_hit & wb_ready_go. Exactly one strobe per instruction.
- csr_re = wb_valid & (csr_re_f | csr_we_f). It is held for the whole residency.
- rf_wdata = csr_re ? csr_rvalue : result. rf_waddr = dest.
- csr_busy = wb_valid & (csr_re_f | csr_we_f); ID uses it to block dependent CSR/GR reads.
- Debug ports mirror rf_we (replicated ×4), dest, rf_wdata and pc.

## Timing
- Latency: one cycle MEM→WB register. Commit is in the cycle after acceptance when CSR_LAT=0, otherwise CSR_LAT cycles later.
- rf_we, csr_we, wb_ex and ertn_flush are one-cycle pulses per instruction and never repeat during a stall.
- Back-to-back instructions with no CSR access retire one per cycle.
- Reset asserted mid-stall: the next cycle has wb_valid=0 and csr_cnt=0, and no commit pulse is generated.
- csr_cnt saturates at 0; CSR_LAT=0 means no counter logic is active.

## Configuration
- WB_PERF_CNT_EN defined:
  - perf_retire_cnt increments on every cycle with wb_valid & wb_ready_go, including exception and ertn instructions. Wraps modulo 2^64.
  - perf_exc_cnt increments on wb_ex. Wraps modulo 2^32.
  - Both are cleared by reset.
- WB_PERF_CNT_EN undefined: both outputs tied to 0 and no counter flops exist.

## Test plan
- Reset held 3 cycles, then released with mem_wb_valid=0 -> all outputs 0; wb_allowin=1.
- ADD, gr_we=1, dest=5, result=32'h1234, CSR_LAT=0 -> one cycle later rf_we=1, debug_wb_rf_wnum=5, rf_wdata=32'h1234. Then 3 back-to-back instructions retire on consecutive cycles.
- csrrd, CSR_LAT=2, csr_num=14'h6, csr_rvalue=32'hABCD -> wb_allowin=0 for 2 cycles, csr_busy=1 throughout. rf_we pulses once with data 32'hABCD.
- exc_vec=4'b0110 (INE and SYS) -> wb_ex=1, wb_ecode=6'h0D, rf_we=0, csr_we=0. An instruction presented the same cycle is dropped (wb_valid=0 next cycle).
- ertn=1 together with exc_vec=4'b0100 -> wb_ex=1, ertn_flush=0. With exc_vec=0 -> ertn_flush=1 for exactly one cycle.
- WB_PERF_CNT_EN defined: retire 10 instructions, 2 of them with an exception -> perf_retire_cnt=10, perf_exc_cnt=2.
